// File: rtl/msg_assembly_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : msg_assembly_ctrl
// Purpose  : Packs the valid bytes of a 64-bit AXI-Stream ingress into whole
//            messages of up to MAX_MSG_BYTES bytes. A completed message is
//            held on a valid/ready port, with ingress backpressure, until it
//            is consumed. Malformed, oversized or upstream-flagged messages
//            are dropped, and each drop raises a one-cycle error pulse.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            s_tvalid/s_tready  - ingress beat handshake
//            s_tdata/s_tkeep    - beat data (byte i = s_tdata[8i+7:8i]) and
//                                 byte enables
//            s_tlast/s_tuser    - end of message / upstream error mark
//            msg_data/msg_length- assembled message and its byte count
//            msg_valid/msg_ready- message output handshake
//            msg_error          - one-cycle pulse per dropped message
//            msg_count/err_count- saturating delivered / dropped counters
// Revision : 1.0 - initial release
// ============================================================================
module msg_assembly_ctrl #(
    parameter int MAX_MSG_BYTES = 32,
    parameter int MIN_MSG_BYTES = 1,
    parameter int TKEEP_WIDTH   = 8,
    localparam int LEN_W        = $clog2(MAX_MSG_BYTES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [63:0]                s_tdata,
    input  logic [TKEEP_WIDTH-1:0]     s_tkeep,
    input  logic                       s_tlast,
    input  logic                       s_tuser,
    output logic [8*MAX_MSG_BYTES-1:0] msg_data,
    output logic [LEN_W-1:0]           msg_length,
    output logic                       msg_valid,
    input  logic                       msg_ready,
    output logic                       msg_error,
    output logic [15:0]                msg_count,
    output logic [15:0]                err_count
);

    localparam int NWORDS = MAX_MSG_BYTES / 8;
    localparam int CNT_W  = $clog2(TKEEP_WIDTH + 1);
    localparam int IDX_W  = (LEN_W > 3) ? (LEN_W - 3) : 1;

    localparam logic [LEN_W:0] MAX_LEN = MAX_MSG_BYTES[LEN_W:0];
    localparam logic [LEN_W:0] MIN_LEN = MIN_MSG_BYTES[LEN_W:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]                 r_state;
    logic [1:0]                 w_next;
    logic [8*MAX_MSG_BYTES-1:0] r_buf;
    logic [LEN_W-1:0]           r_len;
    logic                       r_valid;
    logic                       r_error;
    logic [15:0]                r_msg_cnt;
    logic [15:0]                r_err_cnt;

    logic                       w_accept;
    logic                       w_in_asm;
    logic [TKEEP_WIDTH-1:0]     w_keep_inc;
    logic                       w_keep_contig;
    logic                       w_keep_legal;
    logic [CNT_W-1:0]           w_nbytes;
    logic [LEN_W:0]             w_sum;
    logic                       w_over;
    logic                       w_bad;
    logic                       w_final_err;
    logic                       w_write;
    logic                       w_err;
    logic                       w_deliver;
    logic                       w_clear;
    logic [63:0]                w_beat;
    logic [IDX_W-1:0]           w_word_idx;
    logic [8*MAX_MSG_BYTES-1:0] w_merged;

    // ------------------------------------------------------------------
    // Beat classification
    // ------------------------------------------------------------------
    assign w_accept = s_tvalid && s_tready;
    assign w_in_asm = (r_state == S_IDLE) || (r_state == S_ACCUM);

    // A contiguous-from-LSB mask plus one is a power of two, so the AND
    // of the two is zero only for 01, 03, ..., FF.
    assign w_keep_inc    = s_tkeep + {{(TKEEP_WIDTH-1){1'b0}}, 1'b1};
    assign w_keep_contig = (s_tkeep != '0) && ((s_tkeep & w_keep_inc) == '0);
    assign w_keep_legal  = s_tlast ? w_keep_contig : (s_tkeep == '1);

    always_comb begin
        w_nbytes = '0;
        for (int i = 0; i < TKEEP_WIDTH; i++) begin
            w_nbytes = w_nbytes + {{(CNT_W-1){1'b0}}, s_tkeep[i]};
        end
    end

    assign w_sum       = {1'b0, r_len} + {{(LEN_W+1-CNT_W){1'b0}}, w_nbytes};
    assign w_over      = (w_sum > MAX_LEN);
    assign w_bad       = !w_keep_legal || w_over;
    assign w_final_err = w_bad || s_tuser || (w_sum < MIN_LEN);

    // ------------------------------------------------------------------
    // Byte merge. Every beat ahead of the last one is full, so a write
    // always starts on an 8-byte boundary and lands in exactly one word.
    // Disabled byte lanes are zeroed so unused bytes stay 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_beat = '0;
        for (int k = 0; k < TKEEP_WIDTH; k++) begin
            if (s_tkeep[k]) begin
                w_beat[8*k +: 8] = s_tdata[8*k +: 8];
            end
        end
    end

    assign w_word_idx = r_len[LEN_W-1:LEN_W-IDX_W];

    always_comb begin
        w_merged = r_buf;
        for (int w = 0; w < NWORDS; w++) begin
            if (w_word_idx == IDX_W'(w)) begin
                w_merged[64*w +: 64] = w_beat;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_accept) begin
                    if (s_tlast) begin
                        w_next = w_final_err ? S_IDLE : S_HOLD;
                    end else begin
                        w_next = w_bad ? S_DROP : S_ACCUM;
                    end
                end
            end
            S_DROP: begin
                if (w_accept && s_tlast) begin
                    w_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (msg_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath strobes. s_tready is held low while rst
    // is asserted so no beat is signalled as taken during reset.
    // ------------------------------------------------------------------
    always_comb begin
        s_tready  = (r_state != S_HOLD) && !rst;
        w_write   = w_accept && w_in_asm && !w_bad;
        w_err     = w_accept && s_tlast &&
                    ((w_in_asm && w_final_err) || (r_state == S_DROP));
        w_deliver = (r_state == S_HOLD) && msg_ready;
        // Entering DROP, dropping at tlast and delivering all return the
        // buffer to its cleared state; clear wins over a same-cycle write.
        w_clear   = (w_accept && w_in_asm && w_bad) || w_err || w_deliver;
    end

    // ------------------------------------------------------------------
    // Registered datapath and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf     <= '0;
            r_len     <= '0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_msg_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_valid <= (w_next == S_HOLD);
            r_error <= w_err;
            if (w_clear) begin
                r_buf <= '0;
                r_len <= '0;
            end else if (w_write) begin
                r_buf <= w_merged;
                r_len <= w_sum[LEN_W-1:0];
            end
            if (w_deliver && (r_msg_cnt != 16'hFFFF)) begin
                r_msg_cnt <= r_msg_cnt + 16'd1;
            end
            if (w_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign msg_data   = r_buf;
    assign msg_length = r_len;
    assign msg_valid  = r_valid;
    assign msg_error  = r_error;
    assign msg_count  = r_msg_cnt;
    assign err_count  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_msg_assembly_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_msg_assembly_ctrl
// Purpose  : Scoreboard bench for msg_assembly_ctrl. Each message is scored
//            by a byte-queue reference model when issued; a monitor pops
//            the expected outcome whenever the DUT delivers or drops one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_assembly_ctrl;

    localparam int MAX = 32;
    localparam int MIN = 1;
    localparam int LW  = $clog2(MAX + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             s_tvalid;
    logic             s_tready;
    logic [63:0]      s_tdata;
    logic [7:0]       s_tkeep;
    logic             s_tlast;
    logic             s_tuser;
    logic [8*MAX-1:0] msg_data;
    logic [LW-1:0]    msg_length;
    logic             msg_valid;
    logic             msg_ready;
    logic             msg_error;
    logic [15:0]      msg_count;
    logic [15:0]      err_count;

    msg_assembly_ctrl #(
        .MAX_MSG_BYTES (MAX),
        .MIN_MSG_BYTES (MIN),
        .TKEEP_WIDTH   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tuser    (s_tuser),
        .msg_data   (msg_data),
        .msg_length (msg_length),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_error  (msg_error),
        .msg_count  (msg_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               is_err;
        logic [8*MAX-1:0] data;
        int               len;
    } exp_t;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        bit          l;
        bit          u;
    } beat_t;

    exp_t  exp_q[$];
    beat_t msg[$];

    int n_cmp   = 0;
    int n_fail  = 0;
    int mon_del = 0;
    int mon_err = 0;
    bit rdy_auto = 1'b0;

    task automatic chk(input string name, input logic [8*MAX-1:0] act,
                       input logic [8*MAX-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference model: a message is a byte stream; any bad beat spoils it.
    function automatic exp_t model();
        exp_t       e;
        logic [7:0] bq[$];
        bit         bad = 1'b0;
        int         n;
        bit         legal;
        foreach (msg[i]) begin
            if (!bad) begin
                n     = $countones(msg[i].k);
                legal = (n > 0) && (msg[i].k == 8'((1 << n) - 1)) &&
                        (msg[i].l || n == 8);
                if (!legal || (bq.size() + n > MAX)) begin
                    bad = 1'b1;
                end else begin
                    for (int j = 0; j < n; j++) bq.push_back(msg[i].d[8*j +: 8]);
                end
            end
        end
        if (!bad && (msg[msg.size()-1].u || bq.size() < MIN)) bad = 1'b1;
        e.is_err = bad;
        e.data   = '0;
        e.len    = bad ? 0 : bq.size();
        if (!bad) foreach (bq[j]) e.data[8*j +: 8] = bq[j];
        return e;
    endfunction

    // Build a well-formed message of L bytes with random data.
    task automatic build(input int L);
        beat_t b;
        int    nb;
        int    rem;
        msg.delete();
        nb = (L + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            b.d = {$urandom, $urandom};
            b.l = (i == nb - 1);
            b.u = b.l ? 1'b0 : 1'($urandom);
            rem = L - 8 * i;
            b.k = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
            msg.push_back(b);
        end
    endtask

    task automatic send_beat(input beat_t b);
        int t = 0;
        s_tvalid = 1'b1;
        s_tdata  = b.d;
        s_tkeep  = b.k;
        s_tlast  = b.l;
        s_tuser  = b.u;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            t++;
            if (t > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: got no s_tready expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tdata  = {$urandom, $urandom};
        s_tkeep  = 8'($urandom);
        s_tlast  = 1'($urandom);
        s_tuser  = 1'($urandom);
    endtask

    task automatic send_msg(input bit gaps);
        exp_t e;
        e = model();
        exp_q.push_back(e);
        foreach (msg[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(msg[i]);
        end
        chk("lat_valid", msg_valid, !e.is_err);
        chk("lat_error", msg_error, e.is_err);
        if (e.is_err) begin
            @(posedge clk);
            #1;
            chk("error_one_cycle", msg_error, 0);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_tready", s_tready, 0);
        chk("rst_valid", msg_valid, 0);
        chk("rst_error", msg_error, 0);
        chk("rst_data", msg_data, 0);
        chk("rst_length", msg_length, 0);
        chk("rst_msg_count", msg_count, 0);
        chk("rst_err_count", err_count, 0);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Consumer ready generator (random when enabled).
    initial begin
        msg_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_auto) msg_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops an expectation for each delivery or drop.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (msg_error) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_error: got msg_error expected none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("drop_kind", 1, e.is_err);
                        mon_err++;
                        chk("err_count", err_count, mon_err);
                    end
                end
                if (msg_valid && msg_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_msg: got msg_valid expected none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("deliver_kind", 0, e.is_err);
                        chk("msg_length", msg_length, e.len);
                        chk("msg_data", msg_data, e.data);
                        chk("msg_count", msg_count, mon_del);
                        mon_del++;
                    end
                end
            end
        end
    end

    initial begin
        logic [8*MAX-1:0] d0;
        logic [LW-1:0]    l0;
        beat_t            b;
        int               t;

        rst = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("tready_after_rst", s_tready, 1);
        @(posedge clk); #1;

        // Three beats FF, FF, 0F -> 20 bytes, then hold with ready low.
        build(20);
        send_msg(1'b0);
        chk("len20", msg_length, 20);
        chk("upper_zero", msg_data[8*MAX-1:160], 0);
        d0 = msg_data;
        l0 = msg_length;
        repeat (10) begin
            @(negedge clk);
            chk("hold_tready", s_tready, 0);
            chk("hold_data", msg_data, d0);
            chk("hold_len", msg_length, l0);
        end
        @(posedge clk); #1; msg_ready = 1'b1;
        @(posedge clk); #1; msg_ready = 1'b0;
        chk("tready_after_hs", s_tready, 1);
        chk("count_after_hs", msg_count, 1);
        rdy_auto = 1'b1;

        // Back-to-back: four full beats (exactly MAX) then five beats.
        build(32); send_msg(1'b0);
        build(40); send_msg(1'b0);
        // tuser on last beat, then a clean message.
        build(12); msg[1].u = 1'b1; send_msg(1'b0);
        build(9); send_msg(1'b0);
        // Non-last tkeep 0F, then tkeep 05 on a single last beat.
        build(20); msg[1].k = 8'h0F; send_msg(1'b0);
        build(3); msg[0].k = 8'h05; send_msg(1'b0);
        // Single-byte message in IDLE.
        build(1); send_msg(1'b1);

        // Randomized traffic.
        for (int m = 0; m < 150; m++) begin
            case ($urandom_range(0, 4))
                0: build($urandom_range(MAX + 1, MAX + 12));
                1: begin build($urandom_range(1, MAX)); msg[msg.size()-1].u = 1'b1; end
                2: begin
                    build($urandom_range(9, MAX));
                    msg[$urandom_range(0, msg.size() - 2)].k = 8'($urandom);
                end
                3: begin build($urandom_range(1, MAX)); msg[msg.size()-1].k = 8'($urandom); end
                default: build($urandom_range(1, MAX));
            endcase
            send_msg(1'b1);
        end
        drain();

        // Reset mid-ACCUM.
        rdy_auto = 1'b0;
        @(posedge clk); #1; msg_ready = 1'b0;
        build(24);
        send_beat(msg[0]);
        send_beat(msg[1]);
        rst = 1'b1;
        mon_del = 0;
        mon_err = 0;
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1; rst = 1'b0;

        // Reset while HOLD.
        build(12);
        send_msg(1'b0);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1; rst = 1'b0;

        // Next message assembles from offset 0.
        rdy_auto = 1'b1;
        build(10);
        send_msg(1'b0);
        drain();
        t = 0;
        while (msg_valid && t < 100) begin @(posedge clk); t++; end
        b.d = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msg_assembly_ctrl.md
# msg_assembly_ctrl

Sequences the 64-bit AXI-Stream ingress into whole messages. It accepts beats, packs their valid bytes into a message buffer of up to MAX_MSG_BYTES bytes, and tracks the running byte length. It presents each completed message on a valid/ready output port and applies backpressure while a message waits to be consumed. It sits between the stream slave interface and the downstream message consumer, and it classifies and drops malformed or oversized messages, flagging each one with an error pulse.

## Interface
- MAX_MSG_BYTES, 32, message buffer size in bytes; must be a multiple of 8 and at least 8.
- MIN_MSG_BYTES, 1, smallest legal message length in bytes; range 1..MAX_MSG_BYTES.
- TKEEP_WIDTH, 8, byte-enable width; fixed at 8 because the data bus is 64 bits.
- LEN_W (localparam), $clog2(MAX_MSG_BYTES+1), width of the length output.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous reset, active-high.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  beat ready.
- s_tdata  in  64  beat data; byte i is s_tdata[8i+7:8i].
- s_tkeep  in  TKEEP_WIDTH  byte enables.
- s_tlast  in  1  last beat of the message.
- s_tuser  in  1  upstream error mark; sampled only on the tlast beat.
- msg_data  out  8*MAX_MSG_BYTES  assembled message, byte 0 in the LSBs, zero above msg_length.
- msg_length  out  LEN_W  message byte count.
- msg_valid  out  1  message available.
- msg_ready  in  1  consumer accepts the message.
- msg_error  out  1  one-cycle pulse per dropped message.
- msg_count  out  16  delivered messages; saturates at 16'hFFFF.
- err_count  out  16  dropped messages; saturates at 16'hFFFF.

## Operation
- A beat is accepted when s_tvalid && s_tready. No state changes on cycles without an accept, except the HOLD handshake.
- Legal tkeep is contiguous from the LSB: 8'h01, 8'h03, …, 8'hFF.
  - A non-last beat must have tkeep == 8'hFF.
  - The beat byte count n is popcount(s_tkeep), in the range 1..8.
- Length sum is computed at LEN_W+1 bits. Overflow occurs when len+n > MAX_MSG_BYTES.
- FSM states:
  - IDLE: buffer and len are cleared. On an accepted beat:
    - Legal, no overflow, !tlast → write bytes at offset 0, go to ACCUM.
    - Legal, tlast → go to the final check.
    - Illegal tkeep, or overflow → DROP (or the error path if tlast).
  - ACCUM: write the n bytes at byte offset len, then len += n.
    - Illegal tkeep or overflow → DROP without writing; the buffer contents are discarded.
    - tlast → final check.
  - Final check, on the tlast beat (after merging its bytes):
    - Error if s_tuser == 1, or the final length < MIN_MSG_BYTES, or tkeep is illegal, or overflow.
    - On error: pulse msg_error, increment err_count, go to IDLE.
    - Otherwise: go to HOLD.
  - DROP: accept and discard beats until the tlast beat. On tlast: pulse msg_error, increment err_count, go to IDLE.
    - Only one error is raised per message, however many faults it contains.
  - HOLD:
    - msg_valid = 1; msg_data and msg_length are stable.
    - On msg_ready: increment msg_count, clear the buffer, go to IDLE.
- s_tready = 1 in IDLE, ACCUM and DROP; 0 in HOLD.
- Bytes not written by the message read 0 in msg_data.

## Timing
- Reset values: s_tready=0 while rst is asserted, and 1 from the first cycle after release. msg_valid=0, msg_error=0, msg_data=0, msg_length=0, msg_count=0, err_count=0, FSM=IDLE.
- All outputs are registered, except s_tready, which decodes directly from the state register.
- Latency:
  - The tlast beat accepted in cycle T gives msg_valid=1 in T+1.
  - An error tlast in cycle T gives msg_error=1 in T+1 only.
- The HOLD→IDLE handshake in cycle T gives s_tready=1 in T+1; the next beat can be accepted in T+1. Throughput is one message per (beats+1) cycles with msg_ready held high.
- A single-beat message, with tlast in IDLE, is legal.
- A message of exactly MAX_MSG_BYTES is legal. One byte more is an overflow.
- s_tuser on a non-last beat is ignored.
- Both counters saturate and do not wrap.
- An rst assertion mid-message or in HOLD immediately discards the partial or held message. The counters reset to 0.

## Test plan
- Three beats (0xFF, 0xFF, 0x0F, last), MAX=32:
  - msg_valid one cycle after the last beat, msg_length=20, bytes 20..31 zero.
  - s_tready=0 until msg_ready; msg_count=1.
- Four full beats (32 bytes): accepted, msg_length=32. A five-beat message instead gives DROP, one msg_error pulse after its tlast, err_count=1, no msg_valid.
- Last beat with s_tuser=1 → msg_error pulse at T+1, no msg_valid. The next clean message is delivered normally.
- Non-last beat with tkeep=8'h0F → DROP. A following tlast beat gives a single msg_error. tkeep=8'h05 on a last beat gives an error.
- msg_ready held low for 10 cycles in HOLD:
  - s_tready stays 0 and msg_data/msg_length are stable.
  - msg_ready pulse → s_tready=1 the next cycle, and a back-to-back message is accepted.
- rst pulsed mid-ACCUM and again in HOLD → all outputs at reset values, no msg_valid/msg_error. The next message is assembled from offset 0.
